glitch_sweep: RTL and testbench

Sequencer that walks the glitch engine through a 2-D grid of (clock-edge offset, pulse width) settings, one arm/fire/cooldown cycle per grid point. It sits in the `sysclk` domain beside the glitch engine. It drives the engine's edge-target, pulse-width and arm controls, and reads back the engine's 4-bit state. Each attempt is reported so the command layer can stream results to the host without per-attempt UART traffic.

---
 rtl/glitch_sweep.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_glitch_sweep.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sweep.sv
// glitch_sweep: steps the glitch engine through a grid of (edge offset,
// pulse width) points. Each point gets one arm/fire/cooldown attempt, and
// the outcome of every attempt is reported on a one-cycle o_att_valid pulse.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | waiting for i_start; config is latched on the start pulse
// S_LOAD      | reject an empty grid, otherwise load the first grid point
// S_ARM       | clear per-attempt status, raise o_arm on exit
// S_WAIT_FIRE | engine armed; wait for FIRING or for the timeout to expire
// S_WAIT_COOL | glitch fired; wait for COOLDOWN, then disarm
// S_DRAIN     | disarmed; wait for engine IDLE, then report the attempt
// S_SETTLE    | idle gap between attempts
// S_NEXT      | advance to the next grid point (offset is the inner loop)
// S_FINISH    | emit o_done/o_aborted and return to idle
module glitch_sweep #(
  parameter int W = 32
) (
  input  logic         sysclk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [W-1:0] i_off_start,
  input  logic [15:0]  i_off_step,
  input  logic [15:0]  i_off_count,
  input  logic [W-1:0] i_wid_start,
  input  logic [15:0]  i_wid_step,
  input  logic [15:0]  i_wid_count,
  input  logic [15:0]  i_settle,
  input  logic [W-1:0] i_timeout,
  input  logic [3:0]   i_gl_state,
  output logic [W-1:0] o_clk_edge_target,
  output logic [W-1:0] o_pulsewidth,
  output logic         o_arm,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_aborted,
  output logic         o_att_valid,
  output logic         o_att_fired,
  output logic [W-1:0] o_att_off,
  output logic [W-1:0] o_att_wid
);

  localparam logic [3:0] GL_IDLE     = 4'd0;
  localparam logic [3:0] GL_FIRING   = 4'd3;
  localparam logic [3:0] GL_COOLDOWN = 4'd4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_WAIT_FIRE,
    S_WAIT_COOL,
    S_DRAIN,
    S_SETTLE,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t state_q, state_d;

  // configuration shadow, only written in S_IDLE on an accepted start
  logic [W-1:0] off_start_q, wid_start_q, timeout_q;
  logic [15:0]  off_step_q, off_count_q, wid_step_q, wid_count_q, settle_q;
  logic         cfg_load;

  // sweep position and per-attempt status
  logic [15:0]  off_idx_q, off_idx_d;
  logic [15:0]  wid_idx_q, wid_idx_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic [W-1:0] pw_q, pw_d;
  logic [W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0]  settle_cnt_q, settle_cnt_d;
  logic         fired_q, fired_d;
  logic         abort_q, abort_d;

  // registered outputs
  logic         arm_q, arm_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         aborted_q, aborted_d;
  logic         att_valid_q, att_valid_d;
  logic         att_fired_q, att_fired_d;
  logic [W-1:0] att_off_q, att_off_d;
  logic [W-1:0] att_wid_q, att_wid_d;

  logic [W-1:0] off_step_ext, wid_step_ext, tmo_inc;
  logic         last_off, last_wid;

  assign off_step_ext = {{(W-16){1'b0}}, off_step_q};
  assign wid_step_ext = {{(W-16){1'b0}}, wid_step_q};
  // the timeout counter holds at all-ones instead of wrapping
  assign tmo_inc      = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
  assign last_off     = (off_idx_q == off_count_q - 16'd1);
  assign last_wid     = (wid_idx_q == wid_count_q - 16'd1);

  // Latch the sweep configuration when a start is accepted.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      off_start_q <= '0;
      off_step_q  <= '0;
      off_count_q <= '0;
      wid_start_q <= '0;
      wid_step_q  <= '0;
      wid_count_q <= '0;
      settle_q    <= '0;
      timeout_q   <= '0;
    end else if (cfg_load) begin
      off_start_q <= i_off_start;
      off_step_q  <= i_off_step;
      off_count_q <= i_off_count;
      wid_start_q <= i_wid_start;
      wid_step_q  <= i_wid_step;
      wid_count_q <= i_wid_count;
      settle_q    <= i_settle;
      timeout_q   <= i_timeout;
    end
  end

  // State register and all sweep/output registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      off_idx_q    <= '0;
      wid_idx_q    <= '0;
      tgt_q        <= '0;
      pw_q         <= '0;
      tmo_cnt_q    <= '0;
      settle_cnt_q <= '0;
      fired_q      <= 1'b0;
      abort_q      <= 1'b0;
      arm_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      att_valid_q  <= 1'b0;
      att_fired_q  <= 1'b0;
      att_off_q    <= '0;
      att_wid_q    <= '0;
    end else begin
      state_q      <= state_d;
      off_idx_q    <= off_idx_d;
      wid_idx_q    <= wid_idx_d;
      tgt_q        <= tgt_d;
      pw_q         <= pw_d;
      tmo_cnt_q    <= tmo_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      fired_q      <= fired_d;
      abort_q      <= abort_d;
      arm_q        <= arm_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      att_valid_q  <= att_valid_d;
      att_fired_q  <= att_fired_d;
      att_off_q    <= att_off_d;
      att_wid_q    <= att_wid_d;
    end
  end

  // Next-state and next-output logic; abort is checked first in every state.
  always_comb begin
    state_d      = state_q;
    cfg_load     = 1'b0;
    off_idx_d    = off_idx_q;
    wid_idx_d    = wid_idx_q;
    tgt_d        = tgt_q;
    pw_d         = pw_q;
    tmo_cnt_d    = tmo_cnt_q;
    settle_cnt_d = settle_cnt_q;
    fired_d      = fired_q;
    abort_d      = abort_q;
    arm_d        = arm_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    att_valid_d  = 1'b0;
    att_fired_d  = att_fired_q;
    att_off_d    = att_off_q;
    att_wid_d    = att_wid_q;

    case (state_q)
      S_IDLE: begin
        if (i_abort) begin
          abort_d = 1'b1;
          state_d = S_FINISH;
        end else if (i_start) begin
          cfg_load = 1'b1;
          abort_d  = 1'b0;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        if (i_abort) begin
          abort_d = 1'b1;
          state_d = S_FINISH;
        end else if (off_count_q == 16'd0 || wid_count_q == 16'd0) begin
          state_d = S_FINISH;
        end else begin
          off_idx_d = '0;
          wid_idx_d = '0;
          tgt_d     = off_start_q;
          pw_d      = wid_start_q;
          state_d   = S_ARM;
        end
      end

      S_ARM: begin
        fired_d   = 1'b0;
        tmo_cnt_d = '0;
        if (i_abort) begin
          abort_d = 1'b1;
          arm_d   = 1'b0;
          state_d = S_DRAIN;
        end else begin
          arm_d   = 1'b1;
          state_d = S_WAIT_FIRE;
        end
      end

      S_WAIT_FIRE: begin
        tmo_cnt_d = tmo_inc;
        // a FIRING sample counts as fired even if an abort lands on it
        if (i_gl_state == GL_FIRING) fired_d = 1'b1;
        if (i_abort) begin
          abort_d = 1'b1;
          arm_d   = 1'b0;
          state_d = S_DRAIN;
        end else if (i_gl_state == GL_FIRING) begin
          state_d = S_WAIT_COOL;
        end else if (timeout_q != '0 && tmo_inc == timeout_q) begin
          fired_d = 1'b0;
          arm_d   = 1'b0;
          state_d = S_DRAIN;
        end
      end

      S_WAIT_COOL: begin
        if (i_abort) begin
          abort_d = 1'b1;
          arm_d   = 1'b0;
          state_d = S_DRAIN;
        end else if (i_gl_state == GL_COOLDOWN) begin
          arm_d   = 1'b0;
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // an abort here is remembered; the attempt is still reported
        if (i_abort) abort_d = 1'b1;
        if (i_gl_state == GL_IDLE) begin
          att_valid_d = 1'b1;
          att_fired_d = fired_q;
          att_off_d   = tgt_q;
          att_wid_d   = pw_q;
          if (abort_q || i_abort) begin
            state_d = S_FINISH;
          end else if (settle_q == 16'd0) begin
            state_d = S_NEXT;
          end else begin
            settle_cnt_d = settle_q;
            state_d      = S_SETTLE;
          end
        end
      end

      S_SETTLE: begin
        if (i_abort) begin
          abort_d = 1'b1;
          state_d = S_FINISH;
        end else if (settle_cnt_q <= 16'd1) begin
          settle_cnt_d = '0;
          state_d      = S_NEXT;
        end else begin
          settle_cnt_d = settle_cnt_q - 16'd1;
        end
      end

      S_NEXT: begin
        if (i_abort) begin
          abort_d = 1'b1;
          state_d = S_FINISH;
        end else if (!last_off) begin
          tgt_d     = tgt_q + off_step_ext;
          off_idx_d = off_idx_q + 16'd1;
          state_d   = S_ARM;
        end else begin
          tgt_d     = off_start_q;
          off_idx_d = '0;
          pw_d      = pw_q + wid_step_ext;
          wid_idx_d = wid_idx_q + 16'd1;
          state_d   = last_wid ? S_FINISH : S_ARM;
        end
      end

      S_FINISH: begin
        done_d    = 1'b1;
        aborted_d = abort_q;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign o_clk_edge_target = tgt_q;
  assign o_pulsewidth      = pw_q;
  assign o_arm             = arm_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_aborted         = aborted_q;
  assign o_att_valid       = att_valid_q;
  assign o_att_fired       = att_fired_q;
  assign o_att_off         = att_off_q;
  assign o_att_wid         = att_wid_q;

endmodule

// File: tb/tb_glitch_sweep.sv
// Bench for glitch_sweep: behavioural glitch engine, grid-order reference
// queue, and directed plus randomized sweeps.
module tb_glitch_sweep;
  localparam int W = 32;

  logic         sysclk = 1'b0;
  logic         rst_n;
  logic         i_start, i_abort;
  logic [W-1:0] i_off_start, i_wid_start, i_timeout;
  logic [15:0]  i_off_step, i_off_count, i_wid_step, i_wid_count, i_settle;
  logic [3:0]   gl;
  logic [W-1:0] o_clk_edge_target, o_pulsewidth, o_att_off, o_att_wid;
  logic         o_arm, o_busy, o_done, o_aborted, o_att_valid, o_att_fired;

  glitch_sweep #(.W(W)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_off_start(i_off_start), .i_off_step(i_off_step), .i_off_count(i_off_count),
    .i_wid_start(i_wid_start), .i_wid_step(i_wid_step), .i_wid_count(i_wid_count),
    .i_settle(i_settle), .i_timeout(i_timeout), .i_gl_state(gl),
    .o_clk_edge_target(o_clk_edge_target), .o_pulsewidth(o_pulsewidth),
    .o_arm(o_arm), .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted),
    .o_att_valid(o_att_valid), .o_att_fired(o_att_fired),
    .o_att_off(o_att_off), .o_att_wid(o_att_wid)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [31:0] off;
    logic [31:0] wid;
    logic        fired;
  } att_t;

  att_t exp_q[$];
  int   vec = 0;
  int   miss = 0;

  // engine model knobs/state
  bit   eng_trig = 1'b0;
  int   fire_len = 1;
  int   eng_dly = 0;
  int   eng_fire = 0;

  // monitor state
  bit   mon_chk_len = 1'b0;
  int   exp_len = 0;
  int   arm_len = 0;
  bit   prev_arm = 1'b0;
  int   arm_rises = 0;
  int   att_cnt = 0;
  int   done_cnt = 0;
  logic exp_aborted = 1'b0;
  int   gap = 0;
  bit   gap_act = 1'b0;
  int   cur_settle = 0;
  logic [31:0] last_off = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec++;
    assert (obs === exp_v) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Engine: arm -> ARMED, optional trigger -> WAITING -> FIRING -> COOLDOWN,
  // and any disarm returns it to IDLE. Updated on the falling edge.
  always @(negedge sysclk) begin
    if (!rst_n || !o_arm) begin
      gl = 4'd0;
    end else begin
      case (gl)
        4'd0: begin gl = 4'd1; eng_dly = int'($urandom_range(0, 4)); end
        4'd1: if (eng_trig) begin
                if (eng_dly == 0) gl = 4'd2;
                else eng_dly--;
              end
        4'd2: begin gl = 4'd3; eng_fire = fire_len; end
        4'd3: if (eng_fire <= 1) gl = 4'd4; else eng_fire--;
        default: ;
      endcase
    end
  end

  // Monitor: attempt reports, config held while armed, arm length, settle gap, done.
  always @(negedge sysclk) begin
    att_t e;
    if (o_att_valid) begin
      att_cnt++;
      last_off = o_att_off;
      vec++;
      assert (exp_q.size() > 0) else begin
        miss++;
        $error("FAIL att_extra observed=attempt off=%0h expected=no attempt", o_att_off);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("att_off", o_att_off, e.off);
        chk("att_wid", o_att_wid, e.wid);
        chk("att_fired", {31'd0, o_att_fired}, {31'd0, e.fired});
      end
      gap = 0;
      gap_act = 1'b1;
    end else if (gap_act) begin
      gap++;
    end
    if (o_arm && !prev_arm) begin
      arm_rises++;
      if (gap_act) begin
        chk("settle_gap", gap, cur_settle + 2);
        gap_act = 1'b0;
      end
    end
    if (o_arm) begin
      arm_len++;
      if (exp_q.size() > 0) begin
        chk("tgt_armed", o_clk_edge_target, exp_q[0].off);
        chk("pw_armed", o_pulsewidth, exp_q[0].wid);
      end
    end else if (prev_arm) begin
      if (mon_chk_len) chk("arm_len", arm_len, exp_len);
      arm_len = 0;
    end
    prev_arm = o_arm;
    if (o_done) begin
      done_cnt++;
      chk("done_aborted", {31'd0, o_aborted}, {31'd0, exp_aborted});
      chk("busy_at_done", {31'd0, o_busy}, 32'd0);
      gap_act = 1'b0;
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] os, input logic [15:0] ostep, input logic [15:0] oc,
                         input logic [31:0] ws, input logic [15:0] wstep, input logic [15:0] wc,
                         input logic [15:0] settle, input logic [31:0] tmo);
    i_off_start = os; i_off_step = ostep; i_off_count = oc;
    i_wid_start = ws; i_wid_step = wstep; i_wid_count = wc;
    i_settle = settle; i_timeout = tmo;
  endtask

  // Reference: width is the outer loop, offset the inner, all mod 2^32.
  task automatic build_exp(input logic fired);
    att_t a;
    exp_q.delete();
    cur_settle = int'(i_settle);
    for (int w = 0; w < int'(i_wid_count); w++)
      for (int o = 0; o < int'(i_off_count); o++) begin
        a.off = i_off_start + 32'(o) * {16'd0, i_off_step};
        a.wid = i_wid_start + 32'(w) * {16'd0, i_wid_step};
        a.fired = fired;
        exp_q.push_back(a);
      end
  endtask

  task automatic wait_done(input int bound);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < bound) begin
      tick();
      n++;
    end
    vec++;
    assert (done_cnt != d0) else begin
      miss++;
      $error("FAIL done_timeout observed=no o_done after %0d cycles expected=o_done", bound);
    end
    tick();
  endtask

  task automatic run_sweep(input string tag);
    int a0 = att_cnt;
    int n = exp_q.size();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done(20000);
    chk({tag, "_att_count"}, att_cnt - a0, n);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int a0, r0, d0, n;
    logic [15:0] oc, wc;
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // reset values
    chk("rst_arm", {31'd0, o_arm}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_done", {31'd0, o_done}, 0);
    chk("rst_aborted", {31'd0, o_aborted}, 0);
    chk("rst_att_valid", {31'd0, o_att_valid}, 0);
    chk("rst_tgt", o_clk_edge_target, 0);
    chk("rst_pw", o_pulsewidth, 0);
    chk("rst_att_off", o_att_off, 0);
    rst_n = 1'b1;
    tick();

    // 2x2 sweep with start-to-arm latency
    set_cfg(100, 10, 2, 5, 3, 2, 4, 0);
    eng_trig = 1'b1; exp_aborted = 1'b0; build_exp(1'b1);
    a0 = att_cnt; r0 = arm_rises;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("start_busy", {31'd0, o_busy}, 1);
    chk("start_arm1", {31'd0, o_arm}, 0);
    tick();
    chk("start_arm2", {31'd0, o_arm}, 0);
    tick();
    chk("start_arm3", {31'd0, o_arm}, 1);
    wait_done(2000);
    chk("g2x2_att_count", att_cnt - a0, 4);
    chk("g2x2_arm_rises", arm_rises - r0, 4);
    chk("g2x2_queue_left", exp_q.size(), 0);

    // timeout: engine never triggers
    set_cfg(32'h1000, 16'h100, 2, 32'h40, 2, 2, 1, 50);
    eng_trig = 1'b0; build_exp(1'b0);
    mon_chk_len = 1'b1; exp_len = 50;
    run_sweep("timeout");
    mon_chk_len = 1'b0;

    // zero offset count
    set_cfg(1, 1, 0, 1, 1, 3, 0, 0);
    build_exp(1'b0);
    r0 = arm_rises;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("zero_busy", {31'd0, o_busy}, 1);
    chk("zero_done1", {31'd0, o_done}, 0);
    tick();
    chk("zero_done2", {31'd0, o_done}, 0);
    tick();
    chk("zero_done3", {31'd0, o_done}, 1);
    chk("zero_aborted", {31'd0, o_aborted}, 0);
    tick();
    chk("zero_busy_after", {31'd0, o_busy}, 0);
    chk("zero_arm_rises", arm_rises - r0, 0);

    // abort during WAIT_COOL of attempt 2
    set_cfg(200, 7, 2, 9, 1, 2, 2, 0);
    eng_trig = 1'b1; fire_len = 6; build_exp(1'b1);
    exp_aborted = 1'b1;
    a0 = att_cnt; r0 = arm_rises;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    while (!(att_cnt == a0 + 1 && gl == 4'd3) && n < 1000) begin
      tick();
      n++;
    end
    chk("abort_reached_fire", {31'd0, (gl == 4'd3)}, 1);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_arm_drop", {31'd0, o_arm}, 0);
    wait_done(500);
    repeat (10) tick();
    chk("abort_att_count", att_cnt - a0, 2);
    chk("abort_arm_rises", arm_rises - r0, 2);
    exp_q.delete();
    exp_aborted = 1'b0; fire_len = 1;

    // offset wrap
    set_cfg(32'hFFFFFFF0, 16'h20, 2, 7, 1, 1, 0, 0);
    build_exp(1'b1);
    run_sweep("wrap");
    chk("wrap_second_off", last_off, 32'h0000_0010);

    // asynchronous reset while waiting to fire
    set_cfg(500, 1, 2, 3, 1, 1, 0, 0);
    eng_trig = 1'b0; build_exp(1'b0);
    d0 = done_cnt;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    while (!o_arm && n < 50) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("pre_rst_arm", {31'd0, o_arm}, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_arm", {31'd0, o_arm}, 0);
    chk("async_rst_busy", {31'd0, o_busy}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_no_done", done_cnt - d0, 0);
    exp_q.delete();

    // start while busy is ignored; reports follow the first config
    set_cfg(300, 1, 2, 40, 2, 1, 1, 0);
    eng_trig = 1'b1; build_exp(1'b1);
    a0 = att_cnt;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    chk("busy_before_restart", {31'd0, o_busy}, 1);
    set_cfg(900, 50, 3, 70, 5, 3, 1, 0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done(2000);
    chk("restart_att_count", att_cnt - a0, 2);
    chk("restart_queue_left", exp_q.size(), 0);

    // randomized sweeps
    for (int it = 0; it < 5; it++) begin
      oc = 16'($urandom_range(1, 3));
      wc = 16'($urandom_range(1, 3));
      eng_trig = 1'($urandom_range(0, 1));
      fire_len = int'($urandom_range(1, 3));
      set_cfg($urandom, 16'($urandom_range(0, 16'hFFFF)), oc,
              $urandom, 16'($urandom_range(0, 16'hFFFF)), wc,
              16'($urandom_range(0, 4)),
              eng_trig ? ($urandom_range(0, 1) == 0 ? 32'd0 : 32'd300)
                       : 32'($urandom_range(1, 20)));
      build_exp(eng_trig);
      mon_chk_len = !eng_trig;
      exp_len = int'(i_timeout);
      run_sweep("random");
      mon_chk_len = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=simulation still running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
